hs32_pipe_chain: RTL

//  Parametrised chain of STAGES valid/ready skid registers with per-stage stall, masked flush,
//  per-stage valid taps and occupancy count. Generalises the fixed 4-deep skid-buffered hs32

---
 rtl/hs32_pipe_chain_if.sv | 32 +++
 rtl/hs32_pipe_chain.sv | 104 ++++++++++
 2 files changed

// File: rtl/hs32_pipe_chain_if.sv
// Handshake bundle for hs32_pipe_chain: upstream/downstream valid-ready-data plus
// stall/flush controls and the observation taps.
interface hs32_pipe_chain_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
);
    localparam int unsigned OCC_W = $clog2(2 * STAGES + 1);

    logic              valid_i;
    logic              ready_o;
    logic [WIDTH-1:0]  data_i;
    logic              valid_o;
    logic              ready_i;
    logic [WIDTH-1:0]  data_o;
    logic [STAGES-1:0] stall_i;
    logic              flush_i;
    logic [STAGES-1:0] flush_mask_i;
    logic [STAGES-1:0] stage_vld_o;
    logic [OCC_W-1:0]  occupancy_o;

    // Driver side: produces beats, consumes the output stream, controls stall/flush.
    modport master (
        output valid_i, data_i, ready_i, stall_i, flush_i, flush_mask_i,
        input  ready_o, valid_o, data_o, stage_vld_o, occupancy_o
    );

    // Pipeline side.
    modport slave (
        input  valid_i, data_i, ready_i, stall_i, flush_i, flush_mask_i,
        output ready_o, valid_o, data_o, stage_vld_o, occupancy_o
    );
endinterface

// File: rtl/hs32_pipe_chain.sv
// Chain of STAGES valid/ready skid registers (main + skid per stage) with per-stage
// stall, masked flush, main-valid taps and a registered occupancy count.
module hs32_pipe_chain #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input logic              clk,
    input logic              reset,
    hs32_pipe_chain_if.slave bus
);
    localparam int unsigned OCC_W = $clog2(2 * STAGES + 1);

    logic [STAGES-1:0] main_vld_q, main_vld_d;
    logic [STAGES-1:0] skid_vld_q, skid_vld_d;
    logic [WIDTH-1:0]  main_data_q [STAGES];
    logic [WIDTH-1:0]  main_data_d [STAGES];
    logic [WIDTH-1:0]  skid_data_q [STAGES];
    logic [WIDTH-1:0]  skid_data_d [STAGES];
    logic [OCC_W-1:0]  occ_q, occ_d;

    logic [STAGES-1:0] vin, vout, rdy_in, take_in, take_out;
    logic [WIDTH-1:0]  din [STAGES];

    // Inter-stage wiring: a stalled stage presents a bubble; ready is the registered !skid.
    always_comb begin
        vout   = main_vld_q & ~bus.stall_i;
        vin    = '0;
        rdy_in = '0;
        vin[0] = bus.valid_i;
        din[0] = bus.data_i;
        for (int k = 1; k < int'(STAGES); k++) begin
            vin[k] = vout[k-1];
            din[k] = main_data_q[k-1];
        end
        for (int k = 0; k < int'(STAGES) - 1; k++) begin
            rdy_in[k] = ~skid_vld_q[k+1];
        end
        rdy_in[STAGES-1] = bus.ready_i;
        take_in  = vin & ~skid_vld_q;
        take_out = vout & rdy_in;
    end

    // Per-stage next state: flush beats everything, else refill main from skid or input.
    always_comb begin
        main_vld_d  = main_vld_q;
        skid_vld_d  = skid_vld_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        for (int k = 0; k < int'(STAGES); k++) begin
            if (bus.flush_i && bus.flush_mask_i[k]) begin
                main_vld_d[k] = 1'b0;
                skid_vld_d[k] = 1'b0;
            end else if (!main_vld_q[k] || take_out[k]) begin
                if (skid_vld_q[k]) begin
                    main_vld_d[k]  = 1'b1;
                    main_data_d[k] = skid_data_q[k];
                    skid_vld_d[k]  = 1'b0;
                end else begin
                    main_vld_d[k] = take_in[k];
                    if (take_in[k]) begin
                        main_data_d[k] = din[k];
                    end
                end
            end else if (take_in[k]) begin
                // Main is blocked: park the beat; ready drops on the next cycle.
                skid_vld_d[k]  = 1'b1;
                skid_data_d[k] = din[k];
            end
        end
    end

    // Occupancy tracks the post-edge valid count so it updates with storage.
    always_comb begin
        occ_d = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            occ_d = occ_d + OCC_W'(main_vld_d[k]) + OCC_W'(skid_vld_d[k]);
        end
    end

    // Storage registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_vld_q <= '0;
            skid_vld_q <= '0;
            occ_q      <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                main_data_q[k] <= '0;
                skid_data_q[k] <= '0;
            end
        end else begin
            main_vld_q  <= main_vld_d;
            skid_vld_q  <= skid_vld_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
            occ_q       <= occ_d;
        end
    end

    assign bus.ready_o     = ~skid_vld_q[0];
    assign bus.valid_o     = vout[STAGES-1];
    assign bus.data_o      = main_data_q[STAGES-1];
    assign bus.stage_vld_o = main_vld_q;
    assign bus.occupancy_o = occ_q;
endmodule
